// File: rtl/serializador_tx_pkg.sv
// Shared constants and types for the lane serializer: frame layout, buffer depth
// and the default idle filler byte.
package serializador_tx_pkg;

    localparam int          NUM_LANES         = 4;
    localparam int          BUF_DEPTH         = 2;
    localparam logic [7:0]  IDLE_BYTE_DEFAULT = 8'hBC;
    localparam logic [1:0]  LAST_LANE         = 2'(NUM_LANES - 1);
    localparam logic [1:0]  BUF_FULL_CNT      = 2'(BUF_DEPTH);

    typedef struct packed {
        logic [NUM_LANES-1:0][7:0] data;
        logic [NUM_LANES-1:0]      valid;
    } frame_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/serializador_tx_buffer_tramas.sv
// Two-entry FIFO of captured frames; the head entry is always visible to the
// serializer while a frame is stored.
module buffer_tramas
    import serializador_tx_pkg::*;
(
    input  logic       clk_f,
    input  logic       reset,
    input  logic       push,
    input  frame_t     push_frame,
    input  logic       pop,
    output frame_t     head,
    output logic [1:0] count
);

    frame_t     mem_q [BUF_DEPTH];
    frame_t     mem_d [BUF_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    // Single-bit pointers suffice because the depth is exactly two entries.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && (count_q != BUF_FULL_CNT);
        do_pop   = pop && (count_q != 2'd0);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_frame;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/serializador_tx.sv
// Serializes buffered 4-lane frames onto a byte stream, one lane per clock,
// filling unused or invalid slots with the idle byte.
module serializador_tx
    import serializador_tx_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] data_3,
    input  logic       valid_0,
    input  logic       valid_1,
    input  logic       valid_2,
    input  logic       valid_3,
    input  logic       load,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       IDLE_OUT
);

    state_t     state_q, state_d;
    logic [1:0] lane_cnt_q, lane_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       idle_out_q, idle_out_d;

    frame_t     in_frame;
    frame_t     head;
    logic [1:0] count;
    logic       accept;
    logic       store;
    logic       pop;

    assign in_frame.data  = {data_3, data_2, data_1, data_0};
    assign in_frame.valid = {valid_3, valid_2, valid_1, valid_0};
    assign ready          = (count != BUF_FULL_CNT);
    assign accept         = load && ready;
    // An all-invalid frame completes the handshake but never occupies a slot.
    assign store          = accept && (in_frame.valid != '0);
    assign pop            = (state_q == ST_SEND) && (lane_cnt_q == LAST_LANE);

    buffer_tramas u_buffer_tramas (
        .clk_f      (clk_f),
        .reset      (reset),
        .push       (store),
        .push_frame (in_frame),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        data_out_d  = IDLE_BYTE;
        valid_out_d = 1'b0;
        idle_out_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                lane_cnt_d = 2'd0;
                if (store) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                idle_out_d  = 1'b0;
                valid_out_d = head.valid[lane_cnt_q];
                if (head.valid[lane_cnt_q]) begin
                    data_out_d = head.data[lane_cnt_q];
                end
                lane_cnt_d = lane_cnt_q + 2'd1;
                // Leave SEND only when the last stored frame finishes and nothing new arrives.
                if (pop && (count == 2'd1) && !store) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lane_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lane_cnt_q  <= 2'd0;
            data_out_q  <= IDLE_BYTE;
            valid_out_q <= 1'b0;
            idle_out_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            idle_out_q  <= idle_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign IDLE_OUT  = idle_out_q;

endmodule

// File: tb/tb_serializador_tx.sv
// Randomized scoreboard bench for serializador_tx: every accepted frame becomes four
// time-stamped expected slots, checked by an independent monitor.
module tb_serializador_tx;

    logic       clk_f;
    logic       reset;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       load;
    logic       ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic       IDLE_OUT;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       vld;
    } slot_t;

    slot_t exp_q[$];
    int    cyc      = 0;
    int    last_due = 0;
    int    total    = 0;
    int    bad      = 0;

    serializador_tx #(.IDLE_BYTE(8'hBC)) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .data_3    (data_3),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .valid_2   (valid_2),
        .valid_3   (valid_3),
        .load      (load),
        .ready     (ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .IDLE_OUT  (IDLE_OUT)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    always @(posedge clk_f) cyc = cyc + 1;

    // Monitor: a slot due this cycle must be on the outputs, otherwise the line is idle.
    always @(negedge clk_f) begin
        slot_t s;
        total = total + 1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            s = exp_q.pop_front();
            if (data_out !== s.data || valid_out !== s.vld || IDLE_OUT !== 1'b0) begin
                bad = bad + 1;
                $display("[TB] FAIL slot cyc=%0d: got data=%h valid=%b idle=%b want data=%h valid=%b idle=0",
                         cyc, data_out, valid_out, IDLE_OUT, s.data, s.vld);
            end
        end else begin
            if (data_out !== 8'hBC || valid_out !== 1'b0 || IDLE_OUT !== 1'b1) begin
                bad = bad + 1;
                $display("[TB] FAIL idle cyc=%0d: got data=%h valid=%b idle=%b want data=bc valid=0 idle=1",
                         cyc, data_out, valid_out, IDLE_OUT);
            end
        end
    end

    task automatic check_idle_now(input string tag);
        total = total + 1;
        if (data_out !== 8'hBC || valid_out !== 1'b0 || IDLE_OUT !== 1'b1 || ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got data=%h valid=%b idle=%b ready=%b want data=bc valid=0 idle=1 ready=1",
                     tag, data_out, valid_out, IDLE_OUT, ready);
        end
    endtask

    // One clock of stimulus; the model tracks only how many slots are still pending.
    task automatic drive(input logic ld, input logic [31:0] dat, input logic [3:0] vld, output bit acc);
        int rem;
        int start;
        bit rdy_m;
        @(negedge clk_f);
        rem   = (last_due > cyc) ? last_due - cyc : 0;
        rdy_m = ((rem + 3) / 4) < 2;
        total = total + 1;
        if (ready !== rdy_m) begin
            bad = bad + 1;
            $display("[TB] FAIL ready cyc=%0d: got %b want %b", cyc, ready, rdy_m);
        end
        load    = ld;
        data_0  = dat[7:0];
        data_1  = dat[15:8];
        data_2  = dat[23:16];
        data_3  = dat[31:24];
        valid_0 = vld[0];
        valid_1 = vld[1];
        valid_2 = vld[2];
        valid_3 = vld[3];
        acc     = ld && rdy_m;
        if (acc && vld != 4'b0000) begin
            start = (last_due > cyc) ? last_due + 1 : cyc + 2;
            for (int i = 0; i < 4; i++) begin
                slot_t s;
                s.due  = start + i;
                s.vld  = vld[i];
                s.data = vld[i] ? dat[8*i +: 8] : 8'hBC;
                exp_q.push_back(s);
            end
            last_due = start + 3;
        end
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom(), 4'($urandom_range(0, 15)), acc);
        end
    endtask

    task automatic offer_until_accepted(input logic [31:0] dat, input logic [3:0] vld);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 12) begin
            drive(1'b1, dat, vld, acc);
            tries = tries + 1;
        end
        if (!acc) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL accept_timeout: got no accept in %0d cycles want accept", tries);
        end
    endtask

    task automatic apply_stimulus();
        bit acc;
        int a_lane1;
        int guard;
        logic [3:0] v;

        // Single full frame, then a frame with alternating invalid lanes.
        drive(1'b1, 32'h44332211, 4'b1111, acc);
        idle_cycles(7);
        drive(1'b1, 32'hDDCCBBAA, 4'b0101, acc);
        idle_cycles(7);

        // All-invalid frame while idle: handshake only.
        drive(1'b1, 32'h12345678, 4'b0000, acc);
        idle_cycles(4);

        // Three frames offered with load held high.
        offer_until_accepted(32'h03020100, 4'b1111);
        offer_until_accepted(32'h13121110, 4'b1111);
        offer_until_accepted(32'h23222120, 4'b1111);
        idle_cycles(14);

        // Asynchronous reset just after lane 1 of a frame with another queued.
        drive(1'b1, 32'h5A4A3A2A, 4'b1111, acc);
        a_lane1 = last_due - 2;
        drive(1'b1, 32'h6B5B4B3B, 4'b1111, acc);
        guard = 0;
        while (cyc < a_lane1 - 1 && guard < 10) begin
            drive(1'b0, 32'h0, 4'b0000, acc);
            guard = guard + 1;
        end
        @(posedge clk_f);
        #3;
        reset = 1'b1;
        exp_q.delete();
        last_due = 0;
        #1;
        check_idle_now("reset_async");
        load    = 1'b1;
        valid_0 = 1'b1;
        valid_1 = 1'b1;
        @(negedge clk_f);
        @(negedge clk_f);
        check_idle_now("reset_held_load");
        @(negedge clk_f);
        reset = 1'b0;
        load  = 1'b0;
        idle_cycles(6);

        // Randomized traffic, including all-invalid frames.
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            drive(1'($urandom_range(0, 2) != 0), $urandom(), v, acc);
        end
        idle_cycles(20);
    endtask

    task automatic check_output();
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("[TB] FAIL drain: got %0d pending slots want 0", exp_q.size());
        end
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        data_0  = 8'h00;
        data_1  = 8'h00;
        data_2  = 8'h00;
        data_3  = 8'h00;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        valid_2 = 1'b0;
        valid_3 = 1'b0;
        #1;
        check_idle_now("reset_state");
        @(negedge clk_f);
        @(negedge clk_f);
        reset = 1'b0;
        apply_stimulus();
        check_output();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
